// File: rtl/signal_extension_unit.sv
// Registered sign/zero extension of an IN_WIDTH operand to the OUT_WIDTH datapath word.
// Zero extension is compiled in only when SIGNAL_EXTENSION_ZERO_EXT_EN is defined.
module signal_extension_unit #(
    parameter int IN_WIDTH  = 11,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 zero_ext,
    input  logic [IN_WIDTH-1:0]  operand,
    output logic [OUT_WIDTH-1:0] data,
    output logic                 out_valid
);

    // Handshake: in_valid qualifies operand/zero_ext on a rising edge; out_valid is high
    // for exactly the one cycle after a capture. There is no ready, so the consumer must
    // take data whenever out_valid is high.

    logic                 fill_bit;
    logic [OUT_WIDTH-1:0] ext_word;
    logic [OUT_WIDTH-1:0] data_d;
    logic [OUT_WIDTH-1:0] data_q;
    logic                 out_valid_d;
    logic                 out_valid_q;

`ifdef SIGNAL_EXTENSION_ZERO_EXT_EN
    always_comb begin
        fill_bit = operand[IN_WIDTH-1];
        if (zero_ext) begin
            fill_bit = 1'b0;
        end
    end
`else
    // Mode pin is kept for pin compatibility but carries no function in this build.
    logic unused_zero_ext;
    assign unused_zero_ext = zero_ext;

    always_comb begin
        fill_bit = operand[IN_WIDTH-1];
    end
`endif

    // Filling the whole word first and then overwriting the low field also covers
    // IN_WIDTH == OUT_WIDTH, where there is no upper field at all.
    always_comb begin
        ext_word                 = {OUT_WIDTH{fill_bit}};
        ext_word[IN_WIDTH-1:0]   = operand;
    end

    always_comb begin
        data_d      = data_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            data_d      = ext_word;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data      = data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_signal_extension_unit.sv
// Directed bench for signal_extension_unit: hand-computed vectors pass through an
// expected queue and are compared one cycle after being applied.
module tb_signal_extension_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        zero_ext;
    logic [10:0] operand;
    logic [15:0] data;
    logic        out_valid;

    int checks   = 0;
    int failures = 0;

    logic [16:0] exp_q[$];

    signal_extension_unit #(
        .IN_WIDTH (11),
        .OUT_WIDTH(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .zero_ext (zero_ext),
        .operand  (operand),
        .data     (data),
        .out_valid(out_valid)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Driver: present one set of inputs, clock one edge, then compare against the
    // expected {out_valid, data} queued for that edge.
    task automatic apply(input string tag, input logic rst, input logic vld, input logic zx,
                         input logic [10:0] op, input logic [15:0] exp_data,
                         input logic exp_valid);
        logic [16:0] e;
        rst_n    = rst;
        in_valid = vld;
        zero_ext = zx;
        operand  = op;
        exp_q.push_back({exp_valid, exp_data});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq({tag, "_data"}, data, e[15:0]);
        check_eq({tag, "_valid"}, {15'd0, out_valid}, {15'd0, e[16]});
    endtask

    initial begin
        logic [15:0] zx_exp;
`ifdef SIGNAL_EXTENSION_ZERO_EXT_EN
        zx_exp = 16'h0555;
`else
        zx_exp = 16'hFD55;
`endif
        rst_n    = 1'b0;
        in_valid = 1'b0;
        zero_ext = 1'b0;
        operand  = '0;
        @(negedge clk);

        apply("reset0", 1'b0, 1'b1, 1'b0, 11'h7FF, 16'h0000, 1'b0);
        apply("reset1", 1'b0, 1'b1, 1'b0, 11'h7FF, 16'h0000, 1'b0);

        apply("neg_sext", 1'b1, 1'b1, 1'b0, 11'h555, 16'hFD55, 1'b1);
        apply("pos_sext", 1'b1, 1'b1, 1'b0, 11'h2AA, 16'h02AA, 1'b1);
        apply("min_neg",  1'b1, 1'b1, 1'b0, 11'h400, 16'hFC00, 1'b1);
        apply("max_pos",  1'b1, 1'b1, 1'b0, 11'h3FF, 16'h03FF, 1'b1);
        apply("zext",     1'b1, 1'b1, 1'b1, 11'h555, zx_exp,   1'b1);
        apply("mix_sext", 1'b1, 1'b1, 1'b0, 11'h555, 16'hFD55, 1'b1);
        apply("zext_neg", 1'b1, 1'b1, 1'b1, 11'h7FF,
              (zx_exp == 16'h0555) ? 16'h07FF : 16'hFFFF, 1'b1);

        apply("hold_cap", 1'b1, 1'b1, 1'b0, 11'h001, 16'h0001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            apply("hold", 1'b1, 1'b0, 1'b0, 11'h7FF, 16'h0001, 1'b0);
        end

        apply("b2b_0", 1'b1, 1'b1, 1'b0, 11'h7FF, 16'hFFFF, 1'b1);
        apply("b2b_1", 1'b1, 1'b1, 1'b0, 11'h000, 16'h0000, 1'b1);
        apply("b2b_1nz", 1'b1, 1'b1, 1'b0, 11'h123, 16'h0123, 1'b1);
        apply("mid_rst", 1'b0, 1'b1, 1'b0, 11'h400, 16'h0000, 1'b0);
        apply("post_rst_idle", 1'b1, 1'b0, 1'b0, 11'h400, 16'h0000, 1'b0);
        apply("first_cap", 1'b1, 1'b1, 1'b0, 11'h400, 16'hFC00, 1'b1);
        apply("after_cap", 1'b1, 1'b0, 1'b0, 11'h000, 16'hFC00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
